// File: rtl/rx_bank_swap_ctrl_if.sv
// Control bus between the bank-swap sequencer and the RX tiles / calibration engine.
// The master side is the sequencer; the slave side drives configuration and cal_done.
interface rx_bank_swap_ctrl_if #(
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned CNT_W   = 16
);
  logic               enable;
  logic [STEP_W-1:0]  step_cycles;
  logic [DWELL_W-1:0] dwell_cycles;
  logic               cal_en;
  logic               cal_done;
  logic               a_pc;
  logic               b_pc;
  logic               a_en;
  logic               b_en;
  logic               sel_a;
  logic               cal_req;
  logic               cal_bank_a;
  logic               busy;
  logic [CNT_W-1:0]   swap_count;

  modport master (
    input  enable, step_cycles, dwell_cycles, cal_en, cal_done,
    output a_pc, b_pc, a_en, b_en, sel_a, cal_req, cal_bank_a, busy, swap_count
  );

  modport slave (
    output enable, step_cycles, dwell_cycles, cal_en, cal_done,
    input  a_pc, b_pc, a_en, b_en, sel_a, cal_req, cal_bank_a, busy, swap_count
  );
endinterface

// File: rtl/rx_bank_swap_ctrl.sv
// Make-before-break A/B comparator bank sequencer with programmable step spacing,
// minimum dwell and an optional req/done calibration gate on the parked bank.
module rx_bank_swap_ctrl #(
  parameter int unsigned STEP_W  = 8,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 reset,
  rx_bank_swap_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRel,
    StEn,
    StSel,
    StDis,
    StPc,
    StDwell
  } state_e;

  state_e             state_q;
  logic               tgt_q;        // 1: incoming bank is A
  logic               live_q;       // a bank has been selected since leaving IDLE
  logic [STEP_W-1:0]  step_cnt_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic               a_pc_q;
  logic               b_pc_q;
  logic               a_en_q;
  logic               b_en_q;
  logic               sel_a_q;
  logic               cal_req_q;
  logic               cal_bank_a_q;
  logic               busy_q;
  logic [CNT_W-1:0]   swap_count_q;

  logic [STEP_W-1:0]  step_load;
  logic [DWELL_W-1:0] dwell_load;

  // Counter reload values; zero settings behave as one cycle.
  always_comb begin
    step_load  = '0;
    dwell_load = '0;
    if (bus.step_cycles != '0) begin
      step_load = bus.step_cycles - STEP_W'(1);
    end
    if (bus.dwell_cycles != '0) begin
      dwell_load = bus.dwell_cycles - DWELL_W'(1);
    end
  end

  // Sequencer FSM with all outputs registered on the edge entering each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tgt_q        <= 1'b1;
      live_q       <= 1'b0;
      step_cnt_q   <= '0;
      dwell_cnt_q  <= '0;
      a_pc_q       <= 1'b1;
      b_pc_q       <= 1'b1;
      a_en_q       <= 1'b0;
      b_en_q       <= 1'b0;
      sel_a_q      <= 1'b1;
      cal_req_q    <= 1'b0;
      cal_bank_a_q <= 1'b0;
      busy_q       <= 1'b0;
      swap_count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Stray cal_done is ignored here since cal_req is low.
          if (bus.enable) begin
            tgt_q      <= 1'b1;
            a_pc_q     <= 1'b0;
            busy_q     <= 1'b1;
            step_cnt_q <= step_load;
            state_q    <= StRel;
          end
        end

        StRel: begin
          if (step_cnt_q != '0) begin
            step_cnt_q <= step_cnt_q - STEP_W'(1);
          end else begin
            if (tgt_q) a_en_q <= 1'b1;
            else       b_en_q <= 1'b1;
            step_cnt_q <= step_load;
            state_q    <= StEn;
          end
        end

        StEn: begin
          if (step_cnt_q != '0) begin
            step_cnt_q <= step_cnt_q - STEP_W'(1);
          end else begin
            sel_a_q    <= tgt_q;
            live_q     <= 1'b1;
            step_cnt_q <= step_load;
            state_q    <= StSel;
          end
        end

        StSel: begin
          if (step_cnt_q != '0) begin
            step_cnt_q <= step_cnt_q - STEP_W'(1);
          end else begin
            if (tgt_q) b_en_q <= 1'b0;
            else       a_en_q <= 1'b0;
            step_cnt_q <= step_load;
            state_q    <= StDis;
          end
        end

        StDis: begin
          if (step_cnt_q != '0) begin
            step_cnt_q <= step_cnt_q - STEP_W'(1);
          end else begin
            if (tgt_q) b_pc_q <= 1'b1;
            else       a_pc_q <= 1'b1;
            step_cnt_q <= step_load;
            state_q    <= StPc;
          end
        end

        StPc: begin
          if (step_cnt_q != '0) begin
            step_cnt_q <= step_cnt_q - STEP_W'(1);
          end else begin
            busy_q       <= 1'b0;
            swap_count_q <= swap_count_q + CNT_W'(1);
            dwell_cnt_q  <= dwell_load;
            if (bus.cal_en) begin
              cal_req_q    <= 1'b1;
              cal_bank_a_q <= ~tgt_q;
            end
            state_q <= StDwell;
          end
        end

        StDwell: begin
          if (!bus.enable) begin
            // Abort: park both banks and drop any outstanding calibration request.
            a_pc_q       <= 1'b1;
            b_pc_q       <= 1'b1;
            a_en_q       <= 1'b0;
            b_en_q       <= 1'b0;
            sel_a_q      <= 1'b1;
            cal_req_q    <= 1'b0;
            cal_bank_a_q <= 1'b0;
            busy_q       <= 1'b0;
            live_q       <= 1'b0;
            state_q      <= StIdle;
          end else begin
            if (dwell_cnt_q != '0) begin
              dwell_cnt_q <= dwell_cnt_q - DWELL_W'(1);
            end
            if (cal_req_q && bus.cal_done) begin
              cal_req_q <= 1'b0;
            end
            // Leave only once the request has already been retired on an earlier edge.
            if (dwell_cnt_q == '0 && !cal_req_q) begin
              tgt_q <= ~tgt_q;
              if (tgt_q) b_pc_q <= 1'b0;
              else       a_pc_q <= 1'b0;
              busy_q     <= 1'b1;
              step_cnt_q <= step_load;
              state_q    <= StRel;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // Once a bank has been selected, the selected bank must be released and enabled.
  always_ff @(posedge clk) begin
    if (!reset && live_q) begin
      assert (sel_a_q ? (!a_pc_q && a_en_q) : (!b_pc_q && b_en_q));
    end
  end

  assign bus.a_pc       = a_pc_q;
  assign bus.b_pc       = b_pc_q;
  assign bus.a_en       = a_en_q;
  assign bus.b_en       = b_en_q;
  assign bus.sel_a      = sel_a_q;
  assign bus.cal_req    = cal_req_q;
  assign bus.cal_bank_a = cal_bank_a_q;
  assign bus.busy       = busy_q;
  assign bus.swap_count = swap_count_q;

endmodule

// File: tb/tb_rx_bank_swap_ctrl.sv
// Directed bench for rx_bank_swap_ctrl: expected output snapshots are queued with the
// edge number at which they must hold and compared as the run reaches that edge.
module tb_rx_bank_swap_ctrl;

  localparam logic [11:0] FULL   = 12'hFFF;
  localparam logic [11:0] NOBANK = 12'hFDF;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   n;
  int   r;

  int          at_q[$];
  string       tag_q[$];
  logic [11:0] val_q[$];
  logic [11:0] mask_q[$];

  rx_bank_swap_ctrl_if #(.STEP_W(8), .DWELL_W(16), .CNT_W(4)) bus ();

  rx_bank_swap_ctrl #(.STEP_W(8), .DWELL_W(16), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot order: a_pc a_en b_pc b_en sel_a cal_req cal_bank_a busy swap_count[3:0]
  function automatic logic [11:0] v(input logic apc, input logic aen, input logic bpc,
                                    input logic ben, input logic sel, input logic req,
                                    input logic bank, input logic bsy, input int cnt);
    logic [3:0] c;
    c = 4'(cnt);
    return {apc, aen, bpc, ben, sel, req, bank, bsy, c};
  endfunction

  task automatic expect_at(input int at, input string tag, input logic [11:0] val,
                           input logic [11:0] mask = FULL);
    at_q.push_back(at);
    tag_q.push_back(tag);
    val_q.push_back(val);
    mask_q.push_back(mask);
  endtask

  task automatic check_due();
    logic [11:0] o;
    o = {bus.a_pc, bus.a_en, bus.b_pc, bus.b_en, bus.sel_a, bus.cal_req, bus.cal_bank_a,
         bus.busy, bus.swap_count};
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      checks++;
      if (at_q[0] < cyc) begin
        errors++;
        $error("FAIL %s: not compared at edge %0d (now %0d)", tag_q[0], at_q[0], cyc);
      end else begin
        assert ((o & mask_q[0]) === (val_q[0] & mask_q[0])) else begin
          errors++;
          $error("FAIL %s @%0d: got %b want %b (mask %b)", tag_q[0], cyc, o, val_q[0],
                 mask_q[0]);
        end
      end
      void'(at_q.pop_front());
      void'(tag_q.pop_front());
      void'(val_q.pop_front());
      void'(mask_q.pop_front());
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_due();
    end
  endtask

  task automatic run_to(input int t);
    run(t - cyc);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.enable = 1'b0;
    expect_at(cyc + 1, "reset", v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    run(1);
    reset = 1'b0;
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.step_cycles  = 8'd4;
    bus.dwell_cycles = 16'd20;
    bus.cal_en       = 1'b0;
    bus.cal_done     = 1'b0;

    // Bring-up: reset for 3 cycles, then S=4, D=20, no calibration.
    run(3);
    reset = 1'b0;
    expect_at(cyc, "reset_state", v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    check_due();
    bus.enable = 1'b1;
    n = cyc + 1;
    expect_at(n,      "bu_rel",      v(0, 0, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 3,  "bu_rel_hold", v(0, 0, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 4,  "bu_a_en",     v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 16, "bu_pc",       v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 19, "bu_pre_dw",   v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 20, "bu_dwell",    v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 39, "bu_dw_end",   v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 40, "bu_b_rel",    v(0, 1, 0, 0, 1, 0, 0, 1, 1));
    expect_at(n + 43, "bu_b_rel_h",  v(0, 1, 0, 0, 1, 0, 0, 1, 1));
    expect_at(n + 44, "bu_b_en",     v(0, 1, 0, 1, 1, 0, 0, 1, 1));
    expect_at(n + 47, "bu_sel_h",    v(0, 1, 0, 1, 1, 0, 0, 1, 1));
    expect_at(n + 48, "bu_sel_b",    v(0, 1, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 52, "bu_a_dis",    v(0, 0, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 56, "bu_a_pc",     v(1, 0, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 60, "bu_dwell2",   v(1, 0, 0, 1, 0, 0, 0, 0, 2));
    run_to(n + 60);
    bus.enable = 1'b0;
    expect_at(n + 61, "bu_idle",     v(1, 0, 1, 0, 1, 0, 0, 0, 2));
    run(1);

    // Calibration gating: cal_done returned 50 cycles after cal_req.
    do_reset();
    bus.cal_en = 1'b1;
    bus.enable = 1'b1;
    n = cyc + 1;
    r = n + 20;
    expect_at(r - 1,  "cal_pre",     v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(r,      "cal_req",     v(0, 1, 1, 0, 1, 1, 0, 0, 1));
    expect_at(r + 20, "cal_stall",   v(0, 1, 1, 0, 1, 1, 0, 0, 1));
    expect_at(r + 50, "cal_last",    v(0, 1, 1, 0, 1, 1, 0, 0, 1));
    run_to(r + 50);
    bus.cal_done = 1'b1;
    expect_at(r + 51, "cal_drop",    v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    run(1);
    bus.cal_done = 1'b0;
    expect_at(r + 52, "cal_rel",     v(0, 1, 0, 0, 1, 0, 0, 1, 1));
    expect_at(r + 71, "cal_pre2",    v(1, 0, 0, 1, 0, 0, 0, 1, 1));
    expect_at(r + 72, "cal_req_a",   v(1, 0, 0, 1, 0, 1, 1, 0, 2));
    expect_at(r + 75, "cal_hold_a",  v(1, 0, 0, 1, 0, 1, 1, 0, 2));
    run_to(r + 75);
    // Disable while the request is outstanding.
    bus.enable = 1'b0;
    expect_at(r + 76, "cal_abort",   v(1, 0, 1, 0, 1, 0, 0, 0, 2), NOBANK);
    run(1);
    bus.enable = 1'b1;
    n = cyc + 1;
    expect_at(n,      "re_rel_a",    v(0, 0, 1, 0, 1, 0, 0, 1, 2), NOBANK);
    expect_at(n + 4,  "re_en_a",     v(0, 1, 1, 0, 1, 0, 0, 1, 2), NOBANK);
    expect_at(n + 20, "re_dwell",    v(0, 1, 1, 0, 1, 1, 0, 0, 3));
    run_to(n + 20);
    bus.cal_en = 1'b0;

    // Zero parameters: every state one cycle, swap period six.
    do_reset();
    bus.step_cycles  = 8'd0;
    bus.dwell_cycles = 16'd0;
    bus.enable       = 1'b1;
    n = cyc + 1;
    expect_at(n,      "z_rel",       v(0, 0, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 1,  "z_en",        v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 4,  "z_pc",        v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 5,  "z_dwell1",    v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 6,  "z_rel_b",     v(0, 1, 0, 0, 1, 0, 0, 1, 1));
    expect_at(n + 7,  "z_en_b",      v(0, 1, 0, 1, 1, 0, 0, 1, 1));
    expect_at(n + 8,  "z_sel_b",     v(0, 1, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 9,  "z_dis_a",     v(0, 0, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 10, "z_pc_a",      v(1, 0, 0, 1, 0, 0, 0, 1, 1));
    expect_at(n + 11, "z_dwell2",    v(1, 0, 0, 1, 0, 0, 0, 0, 2));
    expect_at(n + 12, "z_rel_a",     v(0, 0, 0, 1, 0, 0, 0, 1, 2));
    expect_at(n + 13, "z_en_a",      v(0, 1, 0, 1, 0, 0, 0, 1, 2));
    expect_at(n + 14, "z_sel_a",     v(0, 1, 0, 1, 1, 0, 0, 1, 2));
    expect_at(n + 15, "z_dis_b",     v(0, 1, 0, 0, 1, 0, 0, 1, 2));
    expect_at(n + 16, "z_pc_b",      v(0, 1, 1, 0, 1, 0, 0, 1, 2));
    expect_at(n + 17, "z_dwell3",    v(0, 1, 1, 0, 1, 0, 0, 0, 3));
    run_to(n + 17);

    // Disable mid-SEL: transition completes, then IDLE one cycle after DWELL entry.
    do_reset();
    bus.step_cycles  = 8'd4;
    bus.dwell_cycles = 16'd20;
    bus.enable       = 1'b1;
    n = cyc + 1;
    expect_at(n + 8,  "ds_sel",      v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    run_to(n + 9);
    bus.enable = 1'b0;
    expect_at(n + 16, "ds_pc",       v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 19, "ds_pc_end",   v(0, 1, 1, 0, 1, 0, 0, 1, 0));
    expect_at(n + 20, "ds_dwell",    v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 21, "ds_idle",     v(1, 0, 1, 0, 1, 0, 0, 0, 1));
    run_to(n + 21);

    // Reset mid-DIS, then stray cal_done in IDLE.
    bus.enable = 1'b1;
    n = cyc + 1;
    expect_at(n,      "rd_rel",      v(0, 0, 1, 0, 1, 0, 0, 1, 1));
    expect_at(n + 12, "rd_dis",      v(0, 1, 1, 0, 1, 0, 0, 1, 1));
    run_to(n + 13);
    reset      = 1'b1;
    bus.enable = 1'b0;
    expect_at(n + 14, "rd_reset",    v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    run(1);
    reset        = 1'b0;
    bus.cal_done = 1'b1;
    expect_at(cyc + 1, "stray_1",    v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    expect_at(cyc + 2, "stray_2",    v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    run(2);
    bus.cal_done = 1'b0;
    expect_at(cyc + 1, "stray_3",    v(1, 0, 1, 0, 1, 0, 0, 0, 0));
    run(1);

    // Counter wrap with a 4-bit swap counter, S=1, D=1.
    bus.step_cycles  = 8'd1;
    bus.dwell_cycles = 16'd1;
    bus.enable       = 1'b1;
    n = cyc + 1;
    expect_at(n + 5,   "w_dwell1",   v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 89,  "w_dwell15",  v(0, 1, 1, 0, 1, 0, 0, 0, 15));
    expect_at(n + 94,  "w_pc16",     v(1, 0, 0, 1, 0, 0, 0, 1, 15));
    expect_at(n + 95,  "w_dwell16",  v(1, 0, 0, 1, 0, 0, 0, 0, 0));
    expect_at(n + 101, "w_dwell17",  v(0, 1, 1, 0, 1, 0, 0, 0, 1));
    expect_at(n + 102, "w_rel18",    v(0, 1, 0, 0, 1, 0, 0, 1, 1));
    run_to(n + 102);

    if (at_q.size() != 0) begin
      $display("FAIL scoreboard: %0d expectations never compared", at_q.size());
      errors = errors + at_q.size();
      checks = checks + at_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
